frame_store_ctrl: RTL and testbench
===================================

Name: frame_store_ctrl

Overview:
- Captures one processed video frame from the pixel-select output stage into the 8-bit frame BRAM (RGB332), then replays it.
- During replay it generates BRAM read addresses and the `bram_state` / `in_display` controls that the pixel-select stage consumes.
- Sits directly downstream of pixel selection on the write side and upstream of it on the read side.

Parameters:
- FRAME_W, 640, stored frame width in pixels
- FRAME_H, 400, stored frame height in lines
- ADDR_W, 18, BRAM address width (must satisfy 2^ADDR_W >= FRAME_W*FRAME_H)
- RD_LAT, 2, BRAM read latency in clk cycles

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- capture  in  1  debounced user request; rising edge arms a capture
- read_en  in  1  level; when high, the saved frame is displayed
- pixel_in  in  24  RGB888 from pixel-select output, aligned with the three sync inputs below
- blank_in  in  1  delayed blank aligned with `pixel_in` (1 = blanking)
- hsync_in  in  1  delayed hsync, active-low
- vsync_in  in  1  delayed vsync, active-low
- hcount  in  11  live (undelayed) display column
- vcount  in  10  live display row
- bram_addr  out  ADDR_W  BRAM address (write or read)
- bram_din  out  8  RGB332 write data
- bram_we  out  1  BRAM write enable
- bram_state  out  2  00 BRAM_IDLE, 01 CAPTURE_FRAME, 10 WRITING_FRAME, 11 READING_FRAME
- in_display  out  1  pixel currently read from BRAM lies inside the frame; delayed RD_LAT cycles to align with `bram_dout`
- frame_saved  out  1  one-cycle pulse when the last pixel has been written

Behaviour:
- Async reset:
  - State goes to BRAM_IDLE.
  - All outputs go to 0 immediately, including `bram_we`.
  - Internal counters clear.
  - Capture edge detector clears with its stored previous value = 1, so a `capture` held high through reset does not arm.
- Capture edge: `cap_q <= capture`; `cap_rise = capture & ~cap_q`.
- BRAM_IDLE:
  - `cap_rise` -> CAPTURE_FRAME.
  - Otherwise, `read_en` -> READING_FRAME.
- CAPTURE_FRAME:
  - Waits for `vsync_in` = 0, then -> WRITING_FRAME.
  - Row counter `wy` = 0, column counter `wx` = 0, write address `wa` = 0.
- WRITING_FRAME, position tracking:
  - `wx` increments each cycle `blank_in` = 0, and clears when `blank_in` = 1.
  - `wy` increments on each 0->1 transition of `blank_in` that follows at least one active pixel.
  - `wy` clears while `vsync_in` = 0.
- WRITING_FRAME, writing:
  - A write occurs when `blank_in` = 0, `wx` < FRAME_W and `wy` < FRAME_H.
  - Registered (1-cycle latency): `bram_we` <= 1, `bram_addr` <= `wa`, `bram_din` <= {R[7:5], G[7:5], B[7:6]}.
  - `wa` then increments.
  - Pixels beyond FRAME_W or FRAME_H are dropped and leave `wa` unchanged.
- WRITING_FRAME, completion:
  - When the write to `wa` = FRAME_W*FRAME_H-1 is issued, `frame_saved` pulses in that same registered cycle.
  - State -> READING_FRAME if `read_en`, else BRAM_IDLE.
  - `bram_we` is 0 from the following cycle.
- WRITING_FRAME, interrupts:
  - `capture` edges are ignored.
  - `read_en` is ignored until the frame is complete.
- READING_FRAME, addressing:
  - `bram_addr` <= `vcount`*FRAME_W + `hcount` (registered) when `hcount` < FRAME_W and `vcount` < FRAME_H; otherwise `bram_addr` holds.
  - `bram_we` = 0.
- READING_FRAME, display flag:
  - `in_display` = (`hcount` < FRAME_W && `vcount` < FRAME_H), registered and delayed so that it asserts exactly RD_LAT+1 cycles after the qualifying `hcount` / `vcount`.
- READING_FRAME, exits:
  - `read_en` = 0 -> BRAM_IDLE; the `in_display` pipeline flushes to 0.
  - `cap_rise` -> CAPTURE_FRAME. This takes priority over `read_en` = 0 when both occur in the same cycle.
- `in_display` is 0 in every state other than READING_FRAME.
- `bram_state` is the registered state encoding, with no extra delay.

Optional Feature:
- FRAME_STORE_DITHER_EN defined:
  - Before truncation, a 2x2 ordered dither is added with saturation at 255.
  - The dither value is indexed by {`wy`[0], `wx`[0]} with table {0, 2, 3, 1}.
  - R and G receive offset `d`<<3; B receives offset `d`<<4.
  - Write latency stays 1 cycle.
- Undefined: plain truncation, as described in Behaviour.

Test Plan:
- Reset held high during WRITING_FRAME with `bram_we` = 1 -> `bram_we`, `bram_state`, `frame_saved` are 0 in the same cycle; state is IDLE after release.
- `capture` pulse in IDLE, then a full 800x525 timing frame with `pixel_in` = 24'hFF8040 -> exactly 256000 writes.
  - Addresses 0..255999, each with `bram_din` = 8'hF1.
  - `frame_saved` pulses once, coincident with address 255999.
- Active line of 700 pixels -> only `wx` 0..639 written; next line starts at address 640; at most 400 rows written.
- `read_en` = 1 after capture with `hcount` = 5, `vcount` = 2 -> `bram_addr` = 1285 one cycle later; `in_display` = 1 exactly RD_LAT+1 cycles after.
  - With `hcount` = 700, `in_display` = 0.
- `capture` edge during WRITING_FRAME -> ignored, write count unaffected.
- `capture` edge and `read_en` falling in the same cycle in READING -> next state CAPTURE_FRAME.
- With FRAME_STORE_DITHER_EN, `pixel_in` = 24'h101010 at `wx` = 0, `wy` = 0 -> `bram_din` = 8'h00; at `wx` = 0, `wy` = 1 -> `bram_din` = 8'h25.

Source files
------------

// File: rtl/frame_store_ctrl_if.sv
// frame_store_ctrl_if: pixel-stage inputs and BRAM/control outputs of the frame store
interface frame_store_ctrl_if #(parameter int ADDR_W = 18);
  logic              capture;
  logic              read_en;
  logic [23:0]       pixel_in;
  logic              blank_in;
  logic              hsync_in;
  logic              vsync_in;
  logic [10:0]       hcount;
  logic [9:0]        vcount;
  logic [ADDR_W-1:0] bram_addr;
  logic [7:0]        bram_din;
  logic              bram_we;
  logic [1:0]        bram_state;
  logic              in_display;
  logic              frame_saved;
  modport master (
    output capture, read_en, pixel_in, blank_in, hsync_in, vsync_in, hcount, vcount,
    input  bram_addr, bram_din, bram_we, bram_state, in_display, frame_saved
  );
  modport slave (
    input  capture, read_en, pixel_in, blank_in, hsync_in, vsync_in, hcount, vcount,
    output bram_addr, bram_din, bram_we, bram_state, in_display, frame_saved
  );
endinterface

// File: rtl/frame_store_ctrl.sv
// frame_store_ctrl: captures one RGB332 frame into BRAM and replays it; FRAME_STORE_DITHER_EN enables 2x2 ordered dither
module frame_store_ctrl #(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 400,
  parameter int ADDR_W  = 18,
  parameter int RD_LAT  = 2
) (
  input logic              clk,
  input logic              reset,
  frame_store_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    BRAM_IDLE     = 2'b00,
    CAPTURE_FRAME = 2'b01,
    WRITING_FRAME = 2'b10,
    READING_FRAME = 2'b11
  } state_t;

  localparam logic [10:0]       FW     = 11'(FRAME_W);
  localparam logic [9:0]        FH     = 10'(FRAME_H);
  localparam logic [ADDR_W-1:0] FWA    = ADDR_W'(FRAME_W);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(FRAME_W * FRAME_H - 1);

  state_t            state_q, state_d;
  logic              cap_q, blank_q;
  logic [10:0]       wx_q, wx_d;
  logic [9:0]        wy_q, wy_d;
  logic [ADDR_W-1:0] wa_q, wa_d, addr_q, addr_d, rd_addr;
  logic [7:0]        din_q, din_d, pix332;
  logic              we_q, we_d, saved_q, saved_d;
  logic [RD_LAT:0]   disp_q, disp_d;
  logic              cap_rise, writing, reading, wr, done, rd_ok;
  logic              unused_bits;

`ifdef FRAME_STORE_DITHER_EN
  logic [1:0] dv;
  logic [8:0] r9, g9, b9;
  // Ordered 2x2 dither with saturation, then truncation to RGB332
  always_comb begin
    dv = ({wy_q[0], wx_q[0]} == 2'b00) ? 2'd0 :
         ({wy_q[0], wx_q[0]} == 2'b01) ? 2'd2 :
         ({wy_q[0], wx_q[0]} == 2'b10) ? 2'd3 : 2'd1;
    r9 = {1'b0, bus.pixel_in[23:16]} + {4'b0, dv, 3'b0};
    g9 = {1'b0, bus.pixel_in[15:8]} + {4'b0, dv, 3'b0};
    b9 = {1'b0, bus.pixel_in[7:0]} + {3'b0, dv, 4'b0};
    pix332 = {r9[8] ? 3'b111 : r9[7:5], g9[8] ? 3'b111 : g9[7:5], b9[8] ? 2'b11 : b9[7:6]};
  end
  assign unused_bits = ^{bus.hsync_in, r9[4:0], g9[4:0], b9[5:0]};
`else
  assign pix332 = {bus.pixel_in[23:21], bus.pixel_in[15:13], bus.pixel_in[7:6]};
  assign unused_bits = ^{bus.hsync_in, bus.pixel_in[20:16], bus.pixel_in[12:8], bus.pixel_in[5:0]};
`endif

  assign rd_addr = FWA * ADDR_W'(bus.vcount) + ADDR_W'(bus.hcount);

  // Next state, write-position tracking, BRAM port and display pipeline
  always_comb begin
    cap_rise = bus.capture & ~cap_q;
    writing  = state_q == WRITING_FRAME;
    reading  = state_q == READING_FRAME;
    wr       = writing && !bus.blank_in && wx_q < FW && wy_q < FH;
    done     = wr && wa_q == LAST_A;
    rd_ok    = bus.hcount < FW && bus.vcount < FH;
    state_d  = state_q;
    case (state_q)
      CAPTURE_FRAME: state_d = bus.vsync_in ? CAPTURE_FRAME : WRITING_FRAME;
      WRITING_FRAME: state_d = !done ? WRITING_FRAME : bus.read_en ? READING_FRAME : BRAM_IDLE;
      default:       state_d = cap_rise ? CAPTURE_FRAME : bus.read_en ? READING_FRAME : BRAM_IDLE;
    endcase
    wx_d    = (writing && !bus.blank_in) ? wx_q + 11'(wx_q != '1) : '0;
    wy_d    = (!writing || !bus.vsync_in) ? '0 : wy_q + 10'(bus.blank_in && !blank_q && wy_q != '1);
    wa_d    = writing ? wa_q + ADDR_W'(wr) : '0;
    we_d    = wr;
    saved_d = done;
    addr_d  = wr ? wa_q : (reading && rd_ok) ? rd_addr : addr_q;
    din_d   = wr ? pix332 : din_q;
    disp_d  = reading ? (RD_LAT + 1)'({disp_q, rd_ok}) : '0;
  end

  // State and datapath registers; capture history resets high so a held button does not arm
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BRAM_IDLE;
      cap_q   <= 1'b1;
      blank_q <= 1'b1;
      wx_q    <= '0;
      wy_q    <= '0;
      wa_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      saved_q <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= bus.capture;
      blank_q <= bus.blank_in;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      wa_q    <= wa_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      saved_q <= saved_d;
      disp_q  <= disp_d;
    end
  end

  assign bus.bram_addr   = addr_q;
  assign bus.bram_din    = din_q;
  assign bus.bram_we     = we_q;
  assign bus.bram_state  = state_q;
  assign bus.frame_saved = saved_q;
  assign bus.in_display  = disp_q[RD_LAT] & reading;
endmodule

// File: tb/tb_frame_store_ctrl.sv
// tb_frame_store_ctrl: scoreboard bench for frame capture, replay addressing and reset
module tb_frame_store_ctrl;
  localparam int FW = 640, FH = 4, AW = 12, RDL = 2, LAST = FW * FH - 1;
  localparam int DT[4] = '{0, 2, 3, 1};
`ifdef FRAME_STORE_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif
  localparam int RH[9] = '{5, 700, 639, 640, 0, 0, 700, 700, 700};
  localparam int RV[9] = '{2, 2, 3, 3, 4, 0, 0, 0, 0};
  localparam int RA[9] = '{1285, 1285, 2559, 2559, 2559, 0, 0, 0, 0};
  localparam int RQ[9] = '{1, 0, 1, 0, 0, 1, 0, 0, 0};

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0, failures = 0, writes = 0, saves = 0;
  bit          sb_on = 1'b0;
  logic [19:0] sbq[$];
  logic [19:0] e;

  frame_store_ctrl_if #(.ADDR_W(AW)) bus();
  frame_store_ctrl #(.FRAME_W(FW), .FRAME_H(FH), .ADDR_W(AW), .RD_LAT(RDL)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to332(input logic [23:0] p, input int x, input int y);
    logic [31:0] r, g, b;
    int d;
    d = DITHER ? DT[(y % 2) * 2 + (x % 2)] : 0;
    r = 32'(p[23:16]) + 32'(d * 8);
    g = 32'(p[15:8]) + 32'(d * 8);
    b = 32'(p[7:0]) + 32'(d * 16);
    if (r > 255) r = 255;
    if (g > 255) g = 255;
    if (b > 255) b = 255;
    return {r[7:5], g[7:5], b[7:6]};
  endfunction

  // Monitor: every BRAM write is matched against the next expected write
  always @(negedge clk) begin
    if (sb_on && !rst) begin
      if (bus.bram_we) begin
        writes++;
        if (bus.frame_saved) saves++;
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: addr %0d din %h, no write expected", bus.bram_addr, bus.bram_din);
        end else begin
          e = sbq.pop_front();
          chk("wr_addr", 32'(bus.bram_addr), 32'(e[19:8]));
          chk("wr_din", 32'(bus.bram_din), 32'(e[7:0]));
          chk("wr_saved", 32'(bus.frame_saved), 32'(e[19:8] == 12'(LAST)));
        end
      end else if (bus.frame_saved) begin
        saves++;
        checks++;
        failures++;
        $display("FAIL saved_without_write: frame_saved 1 while bram_we 0");
      end
    end
  end

  // 800-wide lines: 2 vsync lines, then 6 lines of 700 active pixels
  task automatic run_frame(input bit vary, input int cap_line, input int ren_line);
    logic [23:0] p;
    bit act;
    int y;
    bus.vsync_in = 1'b1;
    bus.blank_in = 1'b1;
    bus.capture  = 1'b1;
    tick();
    bus.capture = 1'b0;
    tick();
    tick();
    for (int line = 0; line < 8; line++) begin
      for (int x = 0; x < 800; x++) begin
        y   = line - 2;
        act = line >= 2 && x < 700;
        p   = vary ? {8'(x), 8'(y * 40 + x), 8'(x * 3)} : 24'hFF8040;
        bus.vsync_in = line >= 2;
        bus.hsync_in = !(x >= 656 && x < 752);
        bus.blank_in = !act;
        bus.pixel_in = p;
        bus.hcount   = 11'(x);
        bus.vcount   = 10'(line);
        bus.capture  = line == cap_line && x == 100;
        if (line == ren_line && x == 0) bus.read_en = 1'b1;
        if (act && y < FH && x < FW) sbq.push_back({12'(y * FW + x), to332(p, x, y)});
        tick();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.capture = 1'b0; bus.read_en = 1'b0; bus.pixel_in = '0; bus.blank_in = 1'b1;
    bus.hsync_in = 1'b1; bus.vsync_in = 1'b1; bus.hcount = '0; bus.vcount = '0;
    #12;
    chk("rst_state", 32'(bus.bram_state), 0);
    chk("rst_we", 32'(bus.bram_we), 0);
    chk("rst_saved", 32'(bus.frame_saved), 0);
    chk("rst_in_display", 32'(bus.in_display), 0);
    chk("rst_addr", 32'(bus.bram_addr), 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("idle_state", 32'(bus.bram_state), 0);

    sb_on = 1'b1;
    writes = 0; saves = 0;
    run_frame(1'b0, -1, -1);
    chk("f1_pending", 32'(sbq.size()), 0);
    chk("f1_writes", 32'(writes), FW * FH);
    chk("f1_saves", 32'(saves), 1);
    chk("f1_state_idle", 32'(bus.bram_state), 0);

    writes = 0; saves = 0;
    run_frame(1'b1, 3, 4);
    chk("f2_pending", 32'(sbq.size()), 0);
    chk("f2_writes", 32'(writes), FW * FH);
    chk("f2_saves", 32'(saves), 1);
    chk("f2_state_read", 32'(bus.bram_state), 3);

    bus.hcount = 11'd700;
    bus.vcount = 10'd0;
    repeat (4) tick();
    chk("rd_flush", 32'(bus.in_display), 0);
    for (int k = 0; k < 9; k++) begin
      bus.hcount = 11'(RH[k]);
      bus.vcount = 10'(RV[k]);
      tick();
      chk("rd_addr", 32'(bus.bram_addr), RA[k]);
      chk("rd_in_display", 32'(bus.in_display), (k >= RDL) ? RQ[k - RDL] : 0);
      chk("rd_we", 32'(bus.bram_we), 0);
    end

    bus.hcount = 11'd5;
    bus.vcount = 10'd2;
    bus.capture = 1'b1;
    bus.read_en = 1'b0;
    tick();
    bus.capture = 1'b0;
    chk("cap_over_exit", 32'(bus.bram_state), 1);
    chk("cap_in_display", 32'(bus.in_display), 0);

    sb_on = 1'b0;
    bus.vsync_in = 1'b0;
    bus.blank_in = 1'b1;
    tick();
    tick();
    chk("rw_state", 32'(bus.bram_state), 2);
    bus.vsync_in = 1'b1;
    bus.blank_in = 1'b0;
    bus.pixel_in = 24'hFFFFFF;
    tick();
    chk("rw_we", 32'(bus.bram_we), 1);
    chk("rw_din", 32'(bus.bram_din), 8'hFF);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", 32'(bus.bram_we), 0);
    chk("arst_state", 32'(bus.bram_state), 0);
    chk("arst_saved", 32'(bus.frame_saved), 0);
    chk("arst_din", 32'(bus.bram_din), 0);
    bus.capture = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("held_cap_no_arm", 32'(bus.bram_state), 0);
    chk("held_cap_we", 32'(bus.bram_we), 0);
    bus.capture = 1'b0;
    tick();
    bus.capture = 1'b1;
    tick();
    chk("cap_after_rst", 32'(bus.bram_state), 1);
    bus.capture = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
